// File: rtl/muldiv_ctrl_pkg.sv
// Shared definitions for the mul/div sequencing controller: the request-op bit indices,
// the FSM state encoding, the divide-by-zero quotient and the op classification helpers.
package muldiv_ctrl_pkg;

  localparam int MD_MUL   = 0;
  localparam int MD_MULH  = 1;
  localparam int MD_MULHU = 2;
  localparam int MD_DIV   = 3;
  localparam int MD_DIVU  = 4;
  localparam int MD_MOD   = 5;
  localparam int MD_MODU  = 6;
  localparam int MD_OP_W  = 7;

  localparam logic [31:0] DIV0_Q = 32'hFFFF_FFFF;

  typedef logic [MD_OP_W-1:0] md_op_t;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_MUL_WAIT  = 3'd1,
    ST_DIV_WAIT  = 3'd2,
    ST_DIV_DRAIN = 3'd3,
    ST_RESP      = 3'd4
  } md_state_e;

  function automatic logic op_is_onehot(input md_op_t op);
    return (op != '0) && ((op & (op - md_op_t'(1))) == '0);
  endfunction

  function automatic logic op_is_mul(input md_op_t op);
    return op_is_onehot(op) && (op[MD_MUL] | op[MD_MULH] | op[MD_MULHU]);
  endfunction

  function automatic logic op_is_div(input md_op_t op);
    return op_is_onehot(op) && (op[MD_DIV] | op[MD_DIVU] | op[MD_MOD] | op[MD_MODU]);
  endfunction

endpackage

// File: rtl/muldiv_ctrl.sv
// Sequences one mul/div at a time: mul answers MUL_LATENCY+1 cycles after accept, div one cycle
// after div_complete, x/0 and bad ops after one cycle; req_ready only in IDLE, result held until taken.
module muldiv_ctrl
  import muldiv_ctrl_pkg::*;
#(
  parameter int MUL_LATENCY = 2
) (
  input  logic               clk,
  input  logic               resetn,
  input  logic               req_valid,
  output logic               req_ready,
  input  logic [MD_OP_W-1:0] req_op,
  input  logic [31:0]        req_src1,
  input  logic [31:0]        req_src2,
  input  logic               flush,
  output logic               resp_valid,
  input  logic               resp_ready,
  output logic [31:0]        resp_result,
  output logic               mul_signed,
  output logic [31:0]        mul_a,
  output logic [31:0]        mul_b,
  input  logic [63:0]        mul_result,
  output logic               div_en,
  output logic               div_signed,
  output logic [31:0]        div_x,
  output logic [31:0]        div_y,
  input  logic [31:0]        div_q,
  input  logic [31:0]        div_r,
  input  logic               div_complete
);

  localparam int CNT_W = $clog2(MUL_LATENCY + 1);
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(MUL_LATENCY);

  md_state_e        state_q, state_d;
  md_op_t           op_q, op_d;
  logic [31:0]      src1_q, src1_d;
  logic [31:0]      src2_q, src2_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [31:0]      result_q, result_d;

  // Anything that is not exactly one op bit yields 0.
  function automatic logic [31:0] sel_result(input md_op_t op, input logic [63:0] prod,
                                             input logic [31:0] quo, input logic [31:0] rem);
    logic [31:0] res;
    res = '0;
    if (op_is_onehot(op)) begin
      if (op[MD_MUL])                      res = prod[31:0];
      else if (op[MD_MULH] | op[MD_MULHU]) res = prod[63:32];
      else if (op[MD_DIV] | op[MD_DIVU])   res = quo;
      else                                 res = rem;
    end
    return res;
  endfunction

  always_comb begin
    state_d  = state_q;
    op_d     = op_q;
    src1_d   = src1_q;
    src2_d   = src2_q;
    cnt_d    = cnt_q;
    result_d = result_q;

    case (state_q)
      ST_IDLE: begin
        if (req_valid && !flush) begin
          op_d   = req_op;
          src1_d = req_src1;
          src2_d = req_src2;
          if (op_is_mul(req_op)) begin
            cnt_d   = CNT_LOAD;
            state_d = ST_MUL_WAIT;
          end else if (op_is_div(req_op) && (req_src2 != '0)) begin
            state_d = ST_DIV_WAIT;
          end else begin
            // Divide by zero never starts the divider; bad ops fall through to 0.
            result_d = sel_result(req_op, '0, DIV0_Q, req_src1);
            state_d  = ST_RESP;
          end
        end
      end

      ST_MUL_WAIT: begin
        cnt_d = cnt_q - CNT_W'(1);
        if (flush) begin
          state_d = ST_IDLE;
        end else if (cnt_d == '0) begin
          result_d = sel_result(op_q, mul_result, '0, '0);
          state_d  = ST_RESP;
        end
      end

      ST_DIV_WAIT: begin
        if (div_complete) begin
          if (flush) begin
            state_d = ST_IDLE;
          end else begin
            result_d = sel_result(op_q, '0, div_q, div_r);
            state_d  = ST_RESP;
          end
        end else if (flush) begin
          state_d = ST_DIV_DRAIN;
        end
      end

      // The divider cannot be aborted, so keep it enabled until it finishes.
      ST_DIV_DRAIN: begin
        if (div_complete) state_d = ST_IDLE;
      end

      ST_RESP: begin
        if (flush || resp_ready) state_d = ST_IDLE;
      end

      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q  <= ST_IDLE;
      op_q     <= '0;
      src1_q   <= '0;
      src2_q   <= '0;
      cnt_q    <= '0;
      result_q <= '0;
    end else begin
      state_q  <= state_d;
      op_q     <= op_d;
      src1_q   <= src1_d;
      src2_q   <= src2_d;
      cnt_q    <= cnt_d;
      result_q <= result_d;
    end
  end

  assign req_ready   = (state_q == ST_IDLE);
  assign resp_valid  = (state_q == ST_RESP);
  assign resp_result = result_q;

  assign mul_signed = op_q[MD_MUL] | op_q[MD_MULH];
  assign mul_a      = src1_q;
  assign mul_b      = src2_q;

  assign div_en     = (state_q == ST_DIV_WAIT) || (state_q == ST_DIV_DRAIN);
  assign div_signed = op_q[MD_DIV] | op_q[MD_MOD];
  assign div_x      = src1_q;
  assign div_y      = src2_q;

endmodule

// File: tb/tb_muldiv_ctrl.sv
// Directed and random bench for muldiv_ctrl with behavioural multiplier/divider stubs
// and an arithmetic reference model for every result.
module tb_muldiv_ctrl;

  localparam int L = 2;
  localparam logic [6:0] OP_MUL   = 7'b0000001;
  localparam logic [6:0] OP_MULH  = 7'b0000010;
  localparam logic [6:0] OP_MULHU = 7'b0000100;
  localparam logic [6:0] OP_DIV   = 7'b0001000;
  localparam logic [6:0] OP_DIVU  = 7'b0010000;
  localparam logic [6:0] OP_MOD   = 7'b0100000;
  localparam logic [6:0] OP_MODU  = 7'b1000000;

  logic        clk = 1'b0;
  logic        resetn;
  logic        req_valid, req_ready;
  logic [6:0]  req_op;
  logic [31:0] req_src1, req_src2;
  logic        flush;
  logic        resp_valid, resp_ready;
  logic [31:0] resp_result;
  logic        mul_signed;
  logic [31:0] mul_a, mul_b;
  logic [63:0] mul_result;
  logic        div_en, div_signed;
  logic [31:0] div_x, div_y, div_q, div_r;
  logic        div_complete;

  int total = 0;
  int bad   = 0;
  int div_lat = 3;
  int div_cnt;

  always #5 clk = ~clk;

  muldiv_ctrl #(.MUL_LATENCY(L)) dut (
    .clk(clk), .resetn(resetn),
    .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
    .req_src1(req_src1), .req_src2(req_src2), .flush(flush),
    .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_result(resp_result),
    .mul_signed(mul_signed), .mul_a(mul_a), .mul_b(mul_b), .mul_result(mul_result),
    .div_en(div_en), .div_signed(div_signed), .div_x(div_x), .div_y(div_y),
    .div_q(div_q), .div_r(div_r), .div_complete(div_complete)
  );

  // Multiplier stub: one register stage, so the product is ready in the capture cycle.
  always @(posedge clk) begin
    logic [63:0] ea, eb;
    ea = mul_signed ? {{32{mul_a[31]}}, mul_a} : {32'b0, mul_a};
    eb = mul_signed ? {{32{mul_b[31]}}, mul_b} : {32'b0, mul_b};
    mul_result <= ea * eb;
  end

  // Divider stub: completes in the div_lat-th cycle that div_en is high.
  always @(posedge clk or negedge resetn) begin
    if (!resetn)                     div_cnt <= 1;
    else if (div_en && !div_complete) div_cnt <= div_cnt + 1;
    else                             div_cnt <= 1;
  end
  assign div_complete = div_en && (div_cnt == div_lat);

  always_comb begin
    longint sx, sy;
    div_q = 32'hDEAD_BEEF;
    div_r = 32'hDEAD_BEEF;
    if (div_y != 0) begin
      if (div_signed) begin
        sx = $signed(div_x);
        sy = $signed(div_y);
        div_q = 32'(sx / sy);
        div_r = 32'(sx % sy);
      end else begin
        div_q = div_x / div_y;
        div_r = div_x % div_y;
      end
    end
  end

  function automatic logic [31:0] ref_result(input logic [6:0] op, input logic [31:0] a, b);
    longint sa, sb;
    longint unsigned ua, ub;
    sa = $signed(a);
    sb = $signed(b);
    ua = {32'b0, a};
    ub = {32'b0, b};
    case (op)
      OP_MUL:   return 32'(ua * ub);
      OP_MULH:  return 32'((sa * sb) >>> 32);
      OP_MULHU: return 32'((ua * ub) >> 32);
      OP_DIV:   return (b == 0) ? 32'hFFFF_FFFF : 32'(sa / sb);
      OP_DIVU:  return (b == 0) ? 32'hFFFF_FFFF : a / b;
      OP_MOD:   return (b == 0) ? a : 32'(sa % sb);
      OP_MODU:  return (b == 0) ? a : a % b;
      default:  return 32'h0;
    endcase
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Presents one request; returns at the falling edge of the cycle after acceptance.
  task automatic accept(input logic [6:0] op, input logic [31:0] a, b);
    @(negedge clk);
    req_valid = 1'b1;
    req_op    = op;
    req_src1  = a;
    req_src2  = b;
    @(negedge clk);
    req_valid = 1'b0;
    req_op    = 7'($urandom);
    req_src1  = $urandom;
    req_src2  = $urandom;
  endtask

  task automatic run_op(input logic [6:0] op, input logic [31:0] a, b,
                        input int dlat, input int hold);
    int n, en, exp_lat, exp_en;
    logic is_mul, is_div;
    logic [31:0] exp, held;
    is_mul  = op inside {OP_MUL, OP_MULH, OP_MULHU};
    is_div  = (op inside {OP_DIV, OP_DIVU, OP_MOD, OP_MODU}) && (b != 0);
    exp_lat = is_mul ? L + 1 : (is_div ? dlat + 1 : 1);
    exp_en  = is_div ? dlat : 0;
    exp     = ref_result(op, a, b);
    div_lat = dlat;
    accept(op, a, b);
    chk("taken", req_ready, 0);
    n  = 1;
    en = 0;
    while (!resp_valid && n < 100) begin
      if (div_en) en++;
      @(negedge clk);
      n++;
    end
    chk("resp_latency", 64'(n), 64'(exp_lat));
    chk("div_en_cycles", 64'(en), 64'(exp_en));
    chk("result", resp_result, exp);
    held = resp_result;
    repeat (hold) begin
      @(negedge clk);
      chk("hold_valid", resp_valid, 1);
      chk("hold_result", resp_result, held);
    end
    resp_ready = 1'b1;
    @(negedge clk);
    resp_ready = 1'b0;
    chk("post_valid", resp_valid, 0);
    chk("post_ready", req_ready, 1);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog expired total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog");
  end

  initial begin
    resetn = 1'b0; req_valid = 1'b0; req_op = '0; req_src1 = '0; req_src2 = '0;
    flush = 1'b0; resp_ready = 1'b0;
    #12;
    chk("rst_req_ready", req_ready, 1);
    chk("rst_resp_valid", resp_valid, 0);
    chk("rst_resp_result", resp_result, 0);
    chk("rst_div_en", div_en, 0);
    chk("rst_mul_a", mul_a, 0);
    chk("rst_div_y", div_y, 0);
    @(negedge clk);
    resetn = 1'b1;

    run_op(OP_MUL,   32'hFFFF_FFFF, 32'h2, 3, 0);
    chk("mul_const", resp_result, 32'hFFFF_FFFE);
    run_op(OP_MULH,  32'hFFFF_FFFF, 32'h2, 3, 0);
    chk("mulh_const", resp_result, 32'hFFFF_FFFF);
    run_op(OP_MULHU, 32'hFFFF_FFFF, 32'h2, 3, 0);
    chk("mulhu_const", resp_result, 32'h0000_0001);
    run_op(OP_DIV,  32'd7, 32'hFFFF_FFFE, 4, 0);
    chk("div_const", resp_result, 32'hFFFF_FFFD);
    run_op(OP_MOD,  32'd7, 32'hFFFF_FFFE, 2, 0);
    chk("mod_const", resp_result, 32'h0000_0001);
    run_op(OP_DIVU, 32'd100, 32'd7, 5, 1);
    chk("divu_const", resp_result, 32'd14);
    run_op(OP_DIVU, 32'd5, 32'd0, 3, 0);
    chk("divu0_const", resp_result, 32'hFFFF_FFFF);
    run_op(OP_MODU, 32'd5, 32'd0, 3, 0);
    chk("modu0_const", resp_result, 32'd5);
    run_op(7'b0000000, 32'd9, 32'd3, 3, 0);
    run_op(7'b0011000, 32'd9, 32'd3, 3, 0);

    // Flush three cycles into a divide: drain until the divider completes.
    div_lat = 6;
    accept(OP_DIV, 32'd1000, 32'd3);
    @(negedge clk);
    @(negedge clk);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    for (int c = 4; c <= 6; c++) begin
      chk("drain_div_en", div_en, 1);
      chk("drain_req_ready", req_ready, 0);
      chk("drain_resp_valid", resp_valid, 0);
      @(negedge clk);
    end
    chk("drain_done_div_en", div_en, 0);
    chk("drain_done_ready", req_ready, 1);
    chk("drain_done_resp", resp_valid, 0);
    run_op(OP_MUL, 32'd1234, 32'd5678, 3, 0);

    // Response held back while a new request waits.
    accept(OP_MUL, 32'd3, 32'd5);
    @(negedge clk);
    @(negedge clk);
    chk("bp_first_valid", resp_valid, 1);
    chk("bp_first_result", resp_result, 32'd15);
    req_valid = 1'b1; req_op = OP_MULHU; req_src1 = 32'hFFFF_FFFF; req_src2 = 32'hFFFF_FFFF;
    repeat (4) begin
      @(negedge clk);
      chk("bp_valid", resp_valid, 1);
      chk("bp_result", resp_result, 32'd15);
      chk("bp_req_ready", req_ready, 0);
    end
    resp_ready = 1'b1;
    @(negedge clk);
    resp_ready = 1'b0;
    chk("bp_rel_valid", resp_valid, 0);
    chk("bp_rel_ready", req_ready, 1);
    @(negedge clk);
    req_valid = 1'b0;
    chk("bp_next_taken", req_ready, 0);
    @(negedge clk);
    chk("bp_next_early", resp_valid, 0);
    @(negedge clk);
    chk("bp_next_valid", resp_valid, 1);
    chk("bp_next_result", resp_result, 32'hFFFF_FFFE);
    resp_ready = 1'b1;
    @(negedge clk);
    resp_ready = 1'b0;

    // Flush in MUL_WAIT.
    accept(OP_MUL, 32'd7, 32'd7);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    chk("mflush_ready", req_ready, 1);
    chk("mflush_valid", resp_valid, 0);
    @(negedge clk);
    chk("mflush_valid2", resp_valid, 0);

    // Flush wins over a same-cycle response handshake.
    accept(OP_MULHU, 32'hFFFF_FFFF, 32'h2);
    @(negedge clk);
    @(negedge clk);
    chk("rflush_pre_valid", resp_valid, 1);
    flush = 1'b1; resp_ready = 1'b1;
    @(negedge clk);
    flush = 1'b0; resp_ready = 1'b0;
    chk("rflush_valid", resp_valid, 0);
    chk("rflush_ready", req_ready, 1);

    // Flush in the same cycle the divider completes.
    div_lat = 2;
    accept(OP_DIVU, 32'd50, 32'd5);
    @(negedge clk);
    chk("cflush_complete", div_complete, 1);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    chk("cflush_valid", resp_valid, 0);
    chk("cflush_ready", req_ready, 1);
    chk("cflush_div_en", div_en, 0);

    // A request presented together with flush is not accepted.
    @(negedge clk);
    req_valid = 1'b1; req_op = OP_DIVU; req_src1 = 32'd9; req_src2 = 32'd0; flush = 1'b1;
    @(negedge clk);
    req_valid = 1'b0; flush = 1'b0;
    chk("iflush_ready", req_ready, 1);
    chk("iflush_valid", resp_valid, 0);
    @(negedge clk);
    chk("iflush_valid2", resp_valid, 0);

    // Asynchronous reset in DIV_WAIT.
    div_lat = 8;
    accept(OP_DIVU, 32'd100, 32'd7);
    chk("arst_pre_div_en", div_en, 1);
    @(negedge clk);
    #2 resetn = 1'b0;
    #1;
    chk("arst_req_ready", req_ready, 1);
    chk("arst_div_en", div_en, 0);
    chk("arst_resp_valid", resp_valid, 0);
    chk("arst_resp_result", resp_result, 0);
    chk("arst_div_x", div_x, 0);
    @(negedge clk);
    resetn = 1'b1;
    @(negedge clk);
    chk("arst_post_ready", req_ready, 1);
    chk("arst_post_div_en", div_en, 0);
    chk("arst_post_valid", resp_valid, 0);
    run_op(OP_MOD, 32'hFFFF_FFF9, 32'd2, 3, 0);

    for (int i = 0; i < 40; i++) begin
      int sel;
      logic [6:0] op;
      logic [31:0] a, b;
      sel = $urandom_range(0, 8);
      op  = (sel < 7) ? (7'(1) << sel) : ((sel == 7) ? 7'b0 : 7'b0100100);
      a   = $urandom;
      b   = $urandom;
      if ($urandom_range(0, 5) == 0) b = 32'd0;
      else if ($urandom_range(0, 3) == 0) b = $urandom_range(1, 9);
      run_op(op, a, b, $urandom_range(1, 6), $urandom_range(0, 3));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
